// File: rtl/event_builder_if.sv
// ---------------------------------------------------------------------------
// event_builder_if
//   Valid/ready event stream between event_builder and the readout/serializer.
//   event_data  : 64-bit head-of-FIFO event word (0 when no word is queued)
//   event_valid : a word is available
//   event_ready : consumer accepts event_data on this edge
//   master = event producer (event_builder), slave = consumer.
// ---------------------------------------------------------------------------
interface event_builder_if;
    logic [63:0] event_data;
    logic        event_valid;
    logic        event_ready;

    modport master (
        output event_data,
        output event_valid,
        input  event_ready
    );

    modport slave (
        input  event_data,
        input  event_valid,
        output event_ready
    );
endinterface

// File: rtl/event_builder.sv
// ---------------------------------------------------------------------------
// event_builder
//   Tags per-channel hits with the current timestamp and the channel's ADC
//   sample, arbitrates pending channels round-robin (one per cycle) and queues
//   64-bit event words in a first-word-fall-through FIFO.
//
//   Ports
//     clk, reset     : master clock, asynchronous active-high reset
//     timestamp_32b  : free-running timestamp, captured verbatim at the hit
//     hit            : per-channel hit strobes, sampled every rising edge
//     adc_data       : channel i sample at [i*ADC_WIDTH +: ADC_WIDTH]
//     clear_drops    : synchronous clear of dropped_hits (wins over increment)
//     evt            : event stream (event_data / event_valid / event_ready)
//     fifo_count     : words stored
//     fifo_full      : fifo_count == FIFO_DEPTH
//     dropped_hits   : saturating count of hits lost to a still-pending channel
//
//   Event word: [63:32] timestamp, [31:24] channel, [23:17] zero,
//               [16] even-parity bit over the whole word, [15:0] ADC sample.
// ---------------------------------------------------------------------------
module event_builder #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADC_WIDTH    = 10,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [31:0]                       timestamp_32b,
    input  logic [NUM_CHANNELS-1:0]           hit,
    input  logic [NUM_CHANNELS*ADC_WIDTH-1:0] adc_data,
    input  logic                              clear_drops,
    event_builder_if.master                   evt,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              fifo_full,
    output logic [15:0]                       dropped_hits
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [CH_W-1:0]         last_grant_q, last_grant_d;
    logic [31:0]             hold_ts_q  [NUM_CHANNELS];
    logic [31:0]             hold_ts_d  [NUM_CHANNELS];
    logic [ADC_WIDTH-1:0]    hold_adc_q [NUM_CHANNELS];
    logic [ADC_WIDTH-1:0]    hold_adc_d [NUM_CHANNELS];
    logic [63:0]             fifo_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [15:0]             drops_q, drops_d;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    logic                    grant_valid;
    logic [CH_W-1:0]         grant_idx;
    logic [63:0]             word_raw;
    logic [63:0]             push_word;
    logic                    push;
    logic                    pop;
    logic [NUM_CHANNELS-1:0] pending_kept;
    logic [NUM_CHANNELS-1:0] capture;
    logic [NUM_CHANNELS-1:0] lost;
    logic [8:0]              lost_cnt;
    logic [16:0]             drops_sum;

    // Round-robin search starting one past the last granted channel. A grant
    // is only issued when the FIFO has room before this cycle's pop, so a full
    // FIFO with a pop pending gives the pop alone and the grant retries.
    always_comb begin
        int cand;
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        if (count_q < CNT_W'(FIFO_DEPTH)) begin
            for (int off = 1; off <= NUM_CHANNELS; off++) begin
                cand = int'(last_grant_q) + off;
                if (cand >= NUM_CHANNELS) begin
                    cand = cand - NUM_CHANNELS;
                end
                if (!grant_valid && pending_q[CH_W'(cand)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(cand);
                end
            end
        end
    end

    // Event word for the granted channel; parity makes the full word even.
    always_comb begin
        word_raw = {hold_ts_q[grant_idx], 8'(grant_idx), 7'b0, 1'b0,
                    16'(hold_adc_q[grant_idx])};
        push_word     = word_raw;
        push_word[16] = ^word_raw;
    end

    // Capture / collision. The granted channel counts as free this cycle, so
    // a hit on it is captured (its old data goes to the FIFO) rather than lost.
    always_comb begin
        pending_kept = pending_q;
        if (grant_valid) begin
            pending_kept[grant_idx] = 1'b0;
        end
        capture   = hit & ~pending_kept;
        lost      = hit &  pending_kept;
        pending_d = pending_kept | hit;

        hold_ts_d  = hold_ts_q;
        hold_adc_d = hold_adc_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (capture[i]) begin
                hold_ts_d[i]  = timestamp_32b;
                hold_adc_d[i] = adc_data[i*ADC_WIDTH +: ADC_WIDTH];
            end
        end

        last_grant_d = grant_valid ? grant_idx : last_grant_q;
    end

    // Saturating lost-hit counter; clear wins over an increment.
    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            lost_cnt = lost_cnt + 9'(lost[i]);
        end
        drops_sum = 17'(drops_q) + 17'(lost_cnt);
        if (clear_drops) begin
            drops_d = '0;
        end else if (drops_sum > 17'h0FFFF) begin
            drops_d = 16'hFFFF;
        end else begin
            drops_d = drops_sum[15:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n).
    always_comb begin
        push     = grant_valid;
        pop      = (count_q != '0) && evt.event_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge value of every other flop, independent of block order.
        if (reset) begin
            pending_q    <= '0;
            last_grant_q <= CH_W'(NUM_CHANNELS - 1);  // channel 0 searched first
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drops_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drops_q      <= drops_d;
        end
    end

    // NOTE: holding registers and FIFO storage carry no reset; they are only
    // read while the matching pending bit or occupancy count says they are
    // valid, and those control flops are reset.
    always_ff @(posedge clk) begin
        hold_ts_q  <= hold_ts_d;
        hold_adc_q <= hold_adc_d;
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: derived from registered state only (no event_ready -> valid path)
    // ---------------------------------------------------------------------
    assign evt.event_valid = (count_q != '0);
    assign evt.event_data  = (count_q != '0) ? fifo_mem[rd_ptr_q] : 64'd0;
    assign fifo_count      = count_q;
    assign fifo_full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign dropped_hits    = drops_q;

endmodule

// File: tb/tb_event_builder.sv
// ---------------------------------------------------------------------------
// tb_event_builder
//   Directed scenarios plus randomized traffic for event_builder, checked
//   every cycle against a queue-based behavioural model.
// ---------------------------------------------------------------------------
module tb_event_builder;

    localparam int NCH   = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       ts;
    logic [NCH-1:0]    hit;
    logic [NCH*AW-1:0] adc_data;
    logic              clear_drops;
    logic [4:0]        fifo_count;
    logic              fifo_full;
    logic [15:0]       dropped_hits;

    event_builder_if evt_if ();

    event_builder #(
        .NUM_CHANNELS (NCH),
        .ADC_WIDTH    (AW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .timestamp_32b (ts),
        .hit           (hit),
        .adc_data      (adc_data),
        .clear_drops   (clear_drops),
        .evt           (evt_if),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .dropped_hits  (dropped_hits)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: FIFO as a queue, channels as plain arrays.
    // ------------------------------------------------------------------
    logic [63:0] m_fifo [$];
    bit          m_pend [NCH];
    logic [31:0] m_ts   [NCH];
    logic [15:0] m_adc  [NCH];
    int          m_last;
    int          m_drops;

    function automatic logic [63:0] make_word(input logic [31:0] t, input int ch,
                                              input logic [15:0] a);
        logic [63:0] w;
        w = {t, 8'(ch), 8'h00, a};
        w[16] = ($countones(w) % 2) == 1;
        return w;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        for (int i = 0; i < NCH; i++) m_pend[i] = 0;
        m_last  = NCH - 1;
        m_drops = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        bit pop_now;
        bit room;
        int g;
        int nd;
        pop_now = (m_fifo.size() > 0) && evt_if.event_ready;
        room    = m_fifo.size() < DEPTH;
        g = -1;
        if (room) begin
            for (int off = 1; off <= NCH; off++) begin
                int c;
                c = (m_last + off) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (pop_now) void'(m_fifo.pop_front());
        if (g >= 0) begin
            m_fifo.push_back(make_word(m_ts[g], g, m_adc[g]));
            m_pend[g] = 0;
            m_last    = g;
        end
        nd = 0;
        for (int i = 0; i < NCH; i++) begin
            if (hit[i]) begin
                if (m_pend[i]) nd++;
                else begin
                    m_pend[i] = 1;
                    m_ts[i]   = ts;
                    m_adc[i]  = 16'(adc_data[i*AW +: AW]);
                end
            end
        end
        if (clear_drops) m_drops = 0;
        else m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
    endtask

    task automatic check_outputs(input string where);
        check({where, " valid"}, 64'(evt_if.event_valid), 64'(m_fifo.size() > 0));
        check({where, " data"},  evt_if.event_data, (m_fifo.size() > 0) ? m_fifo[0] : 64'd0);
        check({where, " count"}, 64'(fifo_count), 64'(m_fifo.size()));
        check({where, " full"},  64'(fifo_full), 64'(m_fifo.size() == DEPTH));
        check({where, " drops"}, 64'(dropped_hits), 64'(m_drops));
    endtask

    // One clock: model and DUT both take the edge, then outputs are compared
    // 1 time unit later. Hit and clear_drops are one-cycle pulses.
    task automatic step(input string where);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(where);
        hit         = '0;
        clear_drops = 1'b0;
    endtask

    task automatic set_adc(input int ch, input logic [AW-1:0] v);
        adc_data[ch*AW +: AW] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        ts                  = '0;
        hit                 = '0;
        adc_data            = '0;
        clear_drops         = 1'b0;
        evt_if.event_ready  = 1'b0;
        for (int i = 0; i < NCH; i++) set_adc(i, AW'($urandom));
        do_reset();

        // --- single hit, explicit expected word --------------------------
        ts = 32'h0000_1234;
        set_adc(2, 10'h2A5);
        hit = 8'b0000_0100;
        step("single N");
        check("single not yet valid", 64'(evt_if.event_valid), 64'd0);
        step("single N+1");
        check("single word", evt_if.event_data, 64'h0000_1234_0201_02A5);
        evt_if.event_ready = 1'b1;
        step("single pop");

        // --- round robin: last_grant = 3, then hits on 0,3,7 -------------
        hit = 8'b0000_1000;
        step("rr prime");
        step("rr prime");
        step("rr prime");
        ts  = 32'hABCD_0000;
        hit = 8'b1000_1001;
        step("rr capture");
        step("rr w1");
        check("rr first ch",  64'(evt_if.event_data[31:24]), 64'd7);
        check("rr first ts",  64'(evt_if.event_data[63:32]), 64'hABCD_0000);
        step("rr w2");
        check("rr second ch", 64'(evt_if.event_data[31:24]), 64'd0);
        step("rr w3");
        check("rr third ch",  64'(evt_if.event_data[31:24]), 64'd3);
        check("rr third ts",  64'(evt_if.event_data[63:32]), 64'hABCD_0000);
        step("rr drain");

        // --- fill the FIFO, drops, clear ---------------------------------
        evt_if.event_ready = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            ts  = ts + 1;
            hit = 8'(1 << (k % NCH));
            step("fill");
        end
        check("fill full", 64'(fifo_full), 64'd1);
        hit = 8'hFF;
        step("full hits");
        hit = 8'hFF;
        step("full hits");
        check("drop count", 64'(dropped_hits), 64'd9);
        clear_drops = 1'b1;
        hit = 8'h01;
        step("clear");
        check("cleared", 64'(dropped_hits), 64'd0);

        // --- pop with a pending grant while full -------------------------
        evt_if.event_ready = 1'b1;
        step("full pop");
        check("full pop count", 64'(fifo_count), 64'd15);
        evt_if.event_ready = 1'b0;
        step("refill");
        check("refill count", 64'(fifo_count), 64'd16);
        evt_if.event_ready = 1'b1;
        for (int k = 0; k < 30; k++) step("drain");

        // --- timestamp wrap ----------------------------------------------
        ts  = 32'hFFFF_FFFF;
        hit = 8'b0000_0010;
        step("wrap a");
        ts  = 32'h0000_0000;
        hit = 8'b0010_0000;
        step("wrap b");
        check("wrap ts hi", 64'(evt_if.event_data[63:32]), 64'hFFFF_FFFF);
        step("wrap c");
        check("wrap ts lo", 64'(evt_if.event_data[63:32]), 64'h0000_0000);
        step("wrap d");
        step("wrap e");

        // --- asynchronous reset with 5 queued and 3 pending --------------
        evt_if.event_ready = 1'b0;
        hit = 8'h1F;
        step("pre-rst");
        hit = 8'h02;
        step("pre-rst");
        step("pre-rst");
        step("pre-rst");
        step("pre-rst");
        hit = 8'hE0;
        step("pre-rst");
        check("pre-rst count", 64'(fifo_count), 64'd5);
        check("pre-rst drops", 64'(dropped_hits), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("async rst valid", 64'(evt_if.event_valid), 64'd0);
        check("async rst count", 64'(fifo_count), 64'd0);
        check("async rst drops", 64'(dropped_hits), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("in reset");
        reset = 1'b0;
        ts  = 32'h0000_0055;
        hit = 8'b0100_0000;
        step("post-rst");
        step("post-rst");
        check("post-rst ch", 64'(evt_if.event_data[31:24]), 64'd6);
        check("post-rst ts", 64'(evt_if.event_data[63:32]), 64'h0000_0055);

        // --- randomized traffic ------------------------------------------
        for (int k = 0; k < 600; k++) begin
            ts = ($urandom_range(0, 15) == 0) ? $urandom : ts + 1;
            for (int i = 0; i < NCH; i++) begin
                set_adc(i, AW'($urandom));
                hit[i] = ($urandom_range(0, 3) == 0);
            end
            evt_if.event_ready = ($urandom_range(0, 2) != 0);
            clear_drops        = ($urandom_range(0, 63) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
